// File: rtl/dec_scan_pkg.sv
// dec_pkg: shared mode encodings and default sizing for the scanning decoder
package dec_pkg;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  localparam int DEF_IN_W = 3;
  localparam int DEF_DWELL = 4;
endpackage

// File: rtl/dec_scan_if.sv
// dec_scan_if: control inputs and registered select outputs of the scanning decoder
interface dec_scan_if #(parameter int IN_W = dec_pkg::DEF_IN_W);
  logic en;
  logic mode;
  logic [IN_W-1:0] in;
  logic [IN_W-1:0] lim;
  logic [2**IN_W-1:0] out;
  logic [IN_W-1:0] idx;
  logic wrap;
  modport master (output en, mode, in, lim, input out, idx, wrap);
  modport slave (input en, mode, in, lim, output out, idx, wrap);
endinterface

// File: rtl/dec_scan_onehot.sv
// dec_onehot: combinational IN_W-to-2^IN_W one-hot decoder with enable
module dec_onehot #(parameter int IN_W = 3) (
  input  logic en,
  input  logic [IN_W-1:0] sel,
  output logic [2**IN_W-1:0] out
);
  localparam int OUT_W = 2**IN_W;
  // one bit set at the selected position, all-zero when disabled
  always_comb out = en ? OUT_W'(1) << sel : '0;
endmodule

// File: rtl/dec_scan.sv
// dec_scan: registered one-hot decoder with direct and dwell-timed auto-scan modes
module dec_scan import dec_pkg::*; #(
  parameter int IN_W = DEF_IN_W,
  parameter int DWELL = DEF_DWELL
) (
  input logic clk,
  input logic rst,
  dec_scan_if.slave bus
);
  localparam int OUT_W = 2**IN_W;
  localparam int CW = $clog2(DWELL + 1);
  logic mode_q;
  logic [CW-1:0] cnt, cnt_d;
  logic [IN_W-1:0] idx_d, nxt;
  logic entry, scan, adv, wrap_d;
  logic [OUT_W-1:0] oh;
  // next index/dwell state; the idx>=lim compare keeps a lowered lim from ever being overrun
  always_comb begin
    scan = bus.mode == MODE_SCAN;
    entry = scan && mode_q == MODE_DIRECT;
    nxt = bus.idx >= bus.lim ? '0 : bus.idx + 1'b1;
    adv = scan && !entry && bus.en && cnt >= CW'(DWELL - 1);
    idx_d = !scan ? bus.in : entry ? '0 : adv ? nxt : bus.idx;
    cnt_d = (!scan || entry || adv) ? '0 : bus.en ? cnt + 1'b1 : cnt;
    wrap_d = adv && nxt == '0;
  end
  dec_onehot #(.IN_W(IN_W)) u_oh (.en(bus.en), .sel(idx_d), .out(oh));
  // state and output registers, reset has priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_DIRECT;
      cnt <= '0;
      bus.idx <= '0;
      bus.out <= '0;
      bus.wrap <= 1'b0;
    end else begin
      mode_q <= bus.mode;
      cnt <= cnt_d;
      bus.idx <= idx_d;
      bus.out <= oh;
      bus.wrap <= wrap_d;
    end
  end
endmodule
